// File: rtl/ad7763_ctrl.sv
// AD7763 bring-up controller: reset pulse, settle wait, serial register writes
// from an AXI-Stream config stream, SYNC pulse, then enables the capture path.
module ad7763_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_CYCLES   = 4,
  parameter int GAP_CYCLES    = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        adc_resetn,
  output logic        adc_syncn,
  output logic        adc_fsin,
  output logic        adc_sdi,
  output logic        capture_en,
  output logic        busy
);

  localparam int MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B = (SYNC_CYCLES > GAP_CYCLES) ? SYNC_CYCLES : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > 32) ? MAX_C : 32;
  localparam int CW    = $clog2(MAX_P);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RESET, ST_SETTLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_SYNC, ST_RUN
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [31:0]     shift_reg, shift_next;
  logic            last_reg, last_next;
  logic            sdi_next;

  // Down-counter holds (remaining cycles - 1) for the current timed state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    last_next  = last_reg;
    sdi_next   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_next = ST_RESET;
          cnt_next   = CW'(RESET_CYCLES - 1);
        end
      end
      ST_RESET: begin
        if (cnt_reg == '0) begin
          state_next = ST_SETTLE;
          cnt_next   = CW'(SETTLE_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) state_next = ST_LOAD;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      ST_LOAD: begin
        if (s_axis_tvalid && s_axis_tready) begin
          state_next = ST_SHIFT;
          shift_next = s_axis_tdata;
          last_next  = s_axis_tlast;
          cnt_next   = CW'(31);
          sdi_next   = s_axis_tdata[31];
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == '0) begin
          state_next = ST_GAP;
          cnt_next   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_next   = cnt_reg - CW'(1);
          shift_next = {shift_reg[30:0], 1'b0};
          sdi_next   = shift_reg[30];
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          if (last_reg) begin
            state_next = ST_SYNC;
            cnt_next   = CW'(SYNC_CYCLES - 1);
          end else begin
            state_next = ST_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_SYNC: begin
        if (cnt_reg == '0) state_next = ST_RUN;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so every output is a flop
  // that changes on the same edge as the state it belongs to.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      last_reg      <= 1'b0;
      adc_resetn    <= 1'b1;
      adc_syncn     <= 1'b1;
      adc_fsin      <= 1'b1;
      adc_sdi       <= 1'b0;
      capture_en    <= 1'b0;
      busy          <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      last_reg      <= last_next;
      adc_resetn    <= (state_next != ST_RESET);
      adc_syncn     <= (state_next != ST_SYNC);
      adc_fsin      <= (state_next != ST_SHIFT);
      adc_sdi       <= sdi_next;
      capture_en    <= (state_next == ST_RUN);
      busy          <= (state_next != ST_IDLE) && (state_next != ST_RUN);
      s_axis_tready <= (state_next == ST_LOAD);
    end
  end

endmodule
